fifo_stream_reader: RTL

Read-side adapter that drains a registered-output synchronous FIFO and presents its contents as a valid/ready stream. It issues `fifo_pop` only when space is guaranteed in a small local buffer, absorbs the FIFO's one-cycle read latency, and never loses or duplicates an entry under downstream back-pressure. It sits between dispatcher queues and the CGRA consumers that need a stallable stream rather than a fire-and-forget pop interface.

---
 rtl/fifo_stream_reader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Drains a registered-output synchronous FIFO into a valid/ready stream.
// A pop is issued only when a buffer slot is free for it, counting the read
// that is still in flight. This absorbs the FIFO's one-cycle read latency
// without losing or duplicating entries under back-pressure.
// Build option: define FIFO_STREAM_READER_ERR_EN to include the pop/return
// consistency check that drives the sticky err output. Without it, err is
// tied low.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fifo_empty,
  output logic                        fifo_pop,
  input  logic [DATA_WIDTH-1:0]       fifo_pop_data,
  input  logic                        fifo_pop_data_valid,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  input  logic                        flush,
  output logic [$clog2(BUF_DEPTH):0]  count,
  output logic                        err
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] DEPTH_W = (PW + 1)'(BUF_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic                  inflight_q, inflight_d;
  logic                  wr_en_s, rd_en_s;
  logic [PW-1:0]         count_s;
  logic [PW:0]           reserved_s;

  // The extra pointer bit makes a plain difference distinguish full from empty.
  assign count_s    = wr_ptr_q - rd_ptr_q;
  assign reserved_s = {1'b0, count_s} + {{PW{1'b0}}, inflight_q};

  assign count   = count_s;
  assign m_valid = (count_s != {PW{1'b0}});
  assign m_data  = buf_q[rd_ptr_q[AW-1:0]];

  // Pop only when a slot is reserved for the returning word; m_ready is not involved.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty && !flush && (reserved_s < DEPTH_W)) begin
      fifo_pop = 1'b1;
    end else begin
      fifo_pop = 1'b0;
    end
  end

  // Buffer write/read enables; flush suppresses both for its cycle.
  always_comb begin
    wr_en_s = 1'b0;
    rd_en_s = 1'b0;
    if (flush) begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
    end else begin
      wr_en_s = fifo_pop_data_valid;
      rd_en_s = m_valid & m_ready;
    end
  end

  // Next-state for pointers and in-flight tracking; flush returns to empty.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = fifo_pop;
    if (flush) begin
      rd_ptr_d   = {PW{1'b0}};
      wr_ptr_d   = {PW{1'b0}};
      inflight_d = 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_en_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Pointer and in-flight registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      inflight_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  // Buffer storage; returning FIFO data lands at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      buf_q[wr_ptr_q[AW-1:0]] <= fifo_pop_data;
    end
  end

`ifdef FIFO_STREAM_READER_ERR_EN
  logic err_q, err_d;

  // Returned data must match the pop from the previous cycle, one for one.
  always_comb begin
    err_d = err_q;
    if (fifo_pop_data_valid != inflight_q) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Sticky error register; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
